if_stage: RTL and testbench
===========================

Name: if_stage

Overview:
Instruction-fetch stage plus IF/ID pipeline register, directly upstream of the ID-stage hazard unit. It holds the PC and issues requests to a variable-latency instruction memory. It obeys the hazard unit's PCWrite/IFIDWrite stall controls and the ID-stage branch/jump redirects. It presents PC+4, the instruction and a valid flag to ID.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset
NOP_INSTR, 32'h0000_0000, instruction word driven into IF/ID on bubble or flush

Ports:
clock  input  1  single clock, rising edge
reset  input  1  asynchronous, active-high; clears all state
PCWrite  input  1  from hazard unit; 0 = hold PC
IFIDWrite  input  1  from hazard unit; 0 = hold IF/ID register
branch_taken  input  1  ID-stage taken branch, redirect request
branch_target  input  32  branch destination
jump  input  1  ID-stage jump, redirect request
jump_target  input  32  jump destination
imem_req  output  1  instruction memory request
imem_addr  output  32  fetch address, always equal to PC register
imem_rdata  input  32  instruction word, valid when imem_ready=1
imem_ready  input  1  memory completes the request this cycle
IFID_PC4  output  32  registered PC+4 of the instruction in ID
IFID_Instr  output  32  registered instruction
IFID_Valid  output  1  1 = IFID_Instr is real, 0 = bubble
fetch_busy  output  1  1 while waiting on memory (FETCH & !imem_ready) or in DRAIN

Behaviour:
- Reset (async, any state): pc=RESET_PC, state=FETCH, IFID_PC4=0, IFID_Instr=NOP_INSTR, IFID_Valid=0, buffer empty, pending target=0. Outputs: imem_req=1 and imem_addr=RESET_PC from the first cycle after reset deasserts.
- advance = PCWrite & IFIDWrite. redirect = branch_taken | jump. target = branch_taken ? branch_target : jump_target, with bits [1:0] forced to 00 (branch_taken wins if both are set).
- Memory contract: imem_req and imem_addr are held stable until imem_ready. Zero-wait memory (ready in the same cycle as req) is supported.
- FETCH (imem_req=1):
  - ready & redirect: discard data; pc<=target; IF/ID <= bubble; stay in FETCH.
  - ready & advance: IF/ID <= {pc+4, imem_rdata, 1}; pc<=pc+4; stay in FETCH.
  - ready & !advance: capture {pc+4, imem_rdata} in the skid buffer; pc held; go to BUFFERED.
  - !ready & redirect: latch target; IF/ID <= bubble; go to DRAIN.
  - !ready & advance: IF/ID <= bubble; pc held.
  - !ready & !advance: all state held.
- BUFFERED (imem_req=0):
  - redirect: drop the buffer; pc<=target; IF/ID <= bubble; go to FETCH.
  - advance: IF/ID <= buffer contents with valid=1; pc<=pc+4; go to FETCH.
  - else: hold.
- DRAIN (imem_req=1, address = old pc):
  - On ready: discard data; pc<=latched target; go to FETCH.
  - A further redirect while in DRAIN overwrites the latched target and IF/ID <= bubble.
- Bubble = {IFID_PC4 unchanged, NOP_INSTR, Valid=0}. A flush (redirect) writes a bubble even when IFIDWrite=0.
- PC arithmetic is 32-bit unsigned; pc+4 wraps 32'hFFFF_FFFC -> 32'h0000_0000.
- Reset mid-request: the request is abandoned and the memory must tolerate req dropping.

Decomposition:
- Shared package holds:
  - state encoding localparams FETCH=2'd0, BUFFERED=2'd1, DRAIN=2'd2
  - NOP_INSTR
  - RESET_PC default
- One natural sub-module: ifid_reg. It is the IF/ID register with load, flush-to-bubble and async reset; if_stage contains the PC, skid buffer and FSM.

Test Plan:
- Reset, zero-wait memory, advance=1 for 4 cycles -> imem_addr 0,4,8,C; IFID_PC4 4,8,C,10 one cycle later; Valid=1 each cycle.
- Memory with 2 wait cycles at pc=8 -> fetch_busy=1 for 2 cycles; IF/ID shows Valid=0 bubbles; imem_addr stays 8; then {IFID_PC4=C, instr} with Valid=1.
- Load-use stall: PCWrite=IFIDWrite=0 for 1 cycle while ready=1 at pc=10 -> IF/ID and pc hold; state BUFFERED, imem_req=0; next cycle IF/ID={14, word@10}, pc=14.
- branch_taken=1, target=0x43 while ready=1 at pc=20 -> IF/ID bubble; next imem_addr=0x40; word@20 never reaches IF/ID.
- jump to 0x100 while request to 0x30 pending 3 cycles -> imem_addr stays 0x30 until ready; data dropped; next imem_addr=0x100; fetch_busy=1 throughout the drain.
- Assert reset in DRAIN and in BUFFERED -> all outputs at reset values immediately (async); imem_addr=RESET_PC after release; pc wrap check from 0xFFFFFFFC -> 0.

Source files
------------

// File: rtl/if_stage_pkg.sv
// Shared definitions for the instruction-fetch stage.
// Contents:
//   fetch_state_t     - fetch FSM encoding (FETCH, BUFFERED, DRAIN)
//   RESET_PC_DEFAULT  - default PC loaded on reset
//   NOP_INSTR_DEFAULT - default instruction word used for IF/ID bubbles
//   word_align        - clears the two low address bits of a redirect target
package if_stage_pkg;

  typedef enum logic [1:0] {
    FETCH    = 2'd0,
    BUFFERED = 2'd1,
    DRAIN    = 2'd2
  } fetch_state_t;

  localparam logic [31:0] RESET_PC_DEFAULT  = 32'h0000_0000;
  localparam logic [31:0] NOP_INSTR_DEFAULT = 32'h0000_0000;

  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return addr & ~32'd3;
  endfunction

endpackage

// File: rtl/if_stage_ifid_reg.sv
// IF/ID pipeline register.
// Ports:
//   clock, reset      - rising-edge clock, async active-high reset
//   load              - capture pc4_in/instr_in as a valid instruction
//   flush             - write a bubble (NOP, valid=0, pc4 unchanged); beats load
//   pc4_in, instr_in  - incoming PC+4 and instruction word
//   pc4, instr, valid - registered contents presented to ID
module ifid_reg
  import if_stage_pkg::*;
#(
  parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEFAULT
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        load,
  input  logic        flush,
  input  logic [31:0] pc4_in,
  input  logic [31:0] instr_in,
  output logic [31:0] pc4,
  output logic [31:0] instr,
  output logic        valid
);

  // A bubble keeps pc4 so ID still sees a sensible return address.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pc4   <= 32'd0;
      instr <= NOP_INSTR;
      valid <= 1'b0;
    end else if (flush) begin
      instr <= NOP_INSTR;
      valid <= 1'b0;
    end else if (load) begin
      pc4   <= pc4_in;
      instr <= instr_in;
      valid <= 1'b1;
    end
  end

endmodule

// File: rtl/if_stage.sv
// Instruction-fetch stage: PC register, one-entry skid buffer, fetch FSM and
// the IF/ID register.
// Ports:
//   clock, reset                  - rising-edge clock, async active-high reset
//   PCWrite, IFIDWrite            - hazard-unit stall controls (0 = hold)
//   branch_taken, branch_target   - ID-stage branch redirect (wins over jump)
//   jump, jump_target             - ID-stage jump redirect
//   imem_req, imem_addr           - fetch request, held stable until imem_ready
//   imem_rdata, imem_ready        - memory response
//   IFID_PC4, IFID_Instr, IFID_Valid - IF/ID register contents
//   fetch_busy                    - waiting on memory or draining a stale fetch
module if_stage
  import if_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = RESET_PC_DEFAULT,
  parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEFAULT
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        PCWrite,
  input  logic        IFIDWrite,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  input  logic        jump,
  input  logic [31:0] jump_target,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        imem_ready,
  output logic [31:0] IFID_PC4,
  output logic [31:0] IFID_Instr,
  output logic        IFID_Valid,
  output logic        fetch_busy
);

  fetch_state_t state;
  logic [31:0]  pc;
  logic [31:0]  buf_pc4;
  logic [31:0]  buf_instr;
  logic [31:0]  pend_target;

  logic         advance;
  logic         redirect;
  logic [31:0]  target;
  logic [31:0]  pc_plus4;

  logic         ifid_load;
  logic         ifid_flush;
  logic [31:0]  ifid_pc4_d;
  logic [31:0]  ifid_instr_d;

  assign advance  = PCWrite & IFIDWrite;
  assign redirect = branch_taken | jump;
  assign target   = word_align(branch_taken ? branch_target : jump_target);
  assign pc_plus4 = pc + 32'd4;

  // The request is dropped while reset is held so an in-flight fetch is
  // abandoned cleanly; no request is made while a word sits in the buffer.
  assign imem_req   = ~reset & (state != BUFFERED);
  assign imem_addr  = pc;
  assign fetch_busy = ~reset & (((state == FETCH) & ~imem_ready) | (state == DRAIN));

  // IF/ID control: a redirect always flushes, even under an IF/ID stall.
  // An advancing pipeline with no word available receives a bubble.
  always_comb begin
    ifid_load    = 1'b0;
    ifid_flush   = 1'b0;
    ifid_pc4_d   = pc_plus4;
    ifid_instr_d = imem_rdata;
    case (state)
      FETCH: begin
        if (redirect)                    ifid_flush = 1'b1;
        else if (imem_ready && advance)  ifid_load  = 1'b1;
        else if (!imem_ready && advance) ifid_flush = 1'b1;
      end
      BUFFERED: begin
        if (redirect) begin
          ifid_flush = 1'b1;
        end else if (advance) begin
          ifid_load    = 1'b1;
          ifid_pc4_d   = buf_pc4;
          ifid_instr_d = buf_instr;
        end
      end
      DRAIN: begin
        if (redirect) ifid_flush = 1'b1;
      end
      default: ;
    endcase
  end

  // Fetch FSM. DRAIN keeps the stale request alive until memory answers,
  // then jumps to the most recently latched redirect target.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state       <= FETCH;
      pc          <= RESET_PC;
      buf_pc4     <= 32'd0;
      buf_instr   <= NOP_INSTR;
      pend_target <= 32'd0;
    end else begin
      case (state)
        FETCH: begin
          if (imem_ready) begin
            if (redirect) begin
              pc <= target;
            end else if (advance) begin
              pc <= pc_plus4;
            end else begin
              buf_pc4   <= pc_plus4;
              buf_instr <= imem_rdata;
              state     <= BUFFERED;
            end
          end else if (redirect) begin
            pend_target <= target;
            state       <= DRAIN;
          end
        end
        BUFFERED: begin
          if (redirect) begin
            pc    <= target;
            state <= FETCH;
          end else if (advance) begin
            pc    <= pc_plus4;
            state <= FETCH;
          end
        end
        DRAIN: begin
          if (imem_ready) begin
            pc    <= redirect ? target : pend_target;
            state <= FETCH;
          end else if (redirect) begin
            pend_target <= target;
          end
        end
        default: state <= FETCH;
      endcase
    end
  end

  ifid_reg #(
    .NOP_INSTR(NOP_INSTR)
  ) u_ifid_reg (
    .clock   (clock),
    .reset   (reset),
    .load    (ifid_load),
    .flush   (ifid_flush),
    .pc4_in  (ifid_pc4_d),
    .instr_in(ifid_instr_d),
    .pc4     (IFID_PC4),
    .instr   (IFID_Instr),
    .valid   (IFID_Valid)
  );

endmodule

// File: tb/tb_if_stage.sv
// Testbench for if_stage: directed scenarios followed by randomized stall,
// redirect, memory-latency and reset traffic, all compared against a
// transaction-level reference model of the fetch stage.
module tb_if_stage;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam logic [31:0] NOP      = 32'h0000_0013;

  localparam int MODE_FETCHING = 0;
  localparam int MODE_HOLDING  = 1;
  localparam int MODE_DRAINING = 2;

  logic        clock;
  logic        reset;
  logic        PCWrite;
  logic        IFIDWrite;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic        jump;
  logic [31:0] jump_target;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        imem_ready;
  logic [31:0] IFID_PC4;
  logic [31:0] IFID_Instr;
  logic        IFID_Valid;
  logic        fetch_busy;

  int assertCount = 0;
  int failCount   = 0;

  // reference model state
  int          mMode;
  logic [31:0] mPc;
  logic [31:0] mHeldPc4;
  logic [31:0] mHeldWord;
  logic [31:0] mTarget;
  logic [31:0] mIfidPc4;
  logic [31:0] mIfidInstr;
  logic        mIfidValid;

  if_stage #(
    .RESET_PC (RESET_PC),
    .NOP_INSTR(NOP)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .PCWrite      (PCWrite),
    .IFIDWrite    (IFIDWrite),
    .branch_taken (branch_taken),
    .branch_target(branch_target),
    .jump         (jump),
    .jump_target  (jump_target),
    .imem_req     (imem_req),
    .imem_addr    (imem_addr),
    .imem_rdata   (imem_rdata),
    .imem_ready   (imem_ready),
    .IFID_PC4     (IFID_PC4),
    .IFID_Instr   (IFID_Instr),
    .IFID_Valid   (IFID_Valid),
    .fetch_busy   (fetch_busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Instruction memory contents: a scrambled function of the address.
  function automatic logic [31:0] memWord(input logic [31:0] addr);
    return (addr * 32'h9E37_79B1) ^ 32'h0BAD_F00D;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    assertCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %h, expected %h", tag, observed, expected);
    end
  endtask

  task automatic modelReset();
    mMode      = MODE_FETCHING;
    mPc        = RESET_PC;
    mHeldPc4   = 32'd0;
    mHeldWord  = 32'd0;
    mTarget    = 32'd0;
    mIfidPc4   = 32'd0;
    mIfidInstr = NOP;
    mIfidValid = 1'b0;
  endtask

  task automatic modelBubble();
    mIfidInstr = NOP;
    mIfidValid = 1'b0;
  endtask

  // One clock of the fetch stage, described as what happens to the
  // outstanding fetch and to the instruction handed to ID.
  task automatic modelStep(input logic pcw, input logic ifw, input logic bt, input logic [31:0] btg,
                           input logic j, input logic [31:0] jtg, input logic rdy);
    logic        adv;
    logic        redir;
    logic [31:0] tgt;
    adv   = pcw && ifw;
    redir = bt || j;
    tgt   = (bt ? btg : jtg);
    tgt   = {tgt[31:2], 2'b00};
    if (mMode == MODE_FETCHING) begin
      if (redir) begin
        modelBubble();
        if (rdy) mPc = tgt;
        else begin
          mTarget = tgt;
          mMode   = MODE_DRAINING;
        end
      end else if (rdy && adv) begin
        mIfidPc4   = mPc + 32'd4;
        mIfidInstr = memWord(mPc);
        mIfidValid = 1'b1;
        mPc        = mPc + 32'd4;
      end else if (rdy) begin
        mHeldPc4  = mPc + 32'd4;
        mHeldWord = memWord(mPc);
        mMode     = MODE_HOLDING;
      end else if (adv) begin
        modelBubble();
      end
    end else if (mMode == MODE_HOLDING) begin
      if (redir) begin
        modelBubble();
        mPc   = tgt;
        mMode = MODE_FETCHING;
      end else if (adv) begin
        mIfidPc4   = mHeldPc4;
        mIfidInstr = mHeldWord;
        mIfidValid = 1'b1;
        mPc        = mPc + 32'd4;
        mMode      = MODE_FETCHING;
      end
    end else begin
      if (redir) begin
        modelBubble();
        mTarget = tgt;
      end
      if (rdy) begin
        mPc   = mTarget;
        mMode = MODE_FETCHING;
      end
    end
  endtask

  // Called at a falling edge: drives one cycle of inputs, checks the
  // request-side outputs, then checks IF/ID at the next falling edge.
  task automatic applyStimulus(input logic pcw, input logic ifw, input logic bt, input logic [31:0] btg,
                               input logic j, input logic [31:0] jtg, input logic rdy);
    PCWrite       = pcw;
    IFIDWrite     = ifw;
    branch_taken  = bt;
    branch_target = btg;
    jump          = j;
    jump_target   = jtg;
    imem_ready    = rdy;
    imem_rdata    = memWord(imem_addr);
    #1;
    checkOutput("imem_req", 32'(imem_req), 32'(mMode != MODE_HOLDING));
    checkOutput("imem_addr", imem_addr, mPc);
    checkOutput("fetch_busy", 32'(fetch_busy),
                32'((mMode == MODE_FETCHING && !rdy) || mMode == MODE_DRAINING));
    modelStep(pcw, ifw, bt, btg, j, jtg, rdy);
    @(negedge clock);
    checkOutput("IFID_PC4", IFID_PC4, mIfidPc4);
    checkOutput("IFID_Instr", IFID_Instr, mIfidInstr);
    checkOutput("IFID_Valid", 32'(IFID_Valid), 32'(mIfidValid));
  endtask

  // Asserts reset part-way through a cycle and checks outputs respond
  // without waiting for a clock edge.
  task automatic doReset();
    #2;
    reset = 1'b1;
    #1;
    checkOutput("rst_IFID_PC4", IFID_PC4, 32'd0);
    checkOutput("rst_IFID_Instr", IFID_Instr, NOP);
    checkOutput("rst_IFID_Valid", 32'(IFID_Valid), 32'd0);
    checkOutput("rst_imem_addr", imem_addr, RESET_PC);
    modelReset();
    @(negedge clock);
    reset = 1'b0;
  endtask

  initial begin
    reset         = 1'b1;
    PCWrite       = 1'b0;
    IFIDWrite     = 1'b0;
    branch_taken  = 1'b0;
    branch_target = 32'd0;
    jump          = 1'b0;
    jump_target   = 32'd0;
    imem_ready    = 1'b0;
    imem_rdata    = 32'd0;
    modelReset();
    @(negedge clock);
    checkOutput("init_IFID_Valid", 32'(IFID_Valid), 32'd0);
    checkOutput("init_IFID_Instr", IFID_Instr, NOP);
    checkOutput("init_imem_addr", imem_addr, RESET_PC);
    reset = 1'b0;

    // zero-wait streaming
    repeat (4) applyStimulus(1'b1, 1'b1, 1'b0, 32'd0, 1'b0, 32'd0, 1'b1);
    checkOutput("stream_pc4", IFID_PC4, 32'h10);
    checkOutput("stream_instr", IFID_Instr, memWord(32'hC));

    // two wait states at pc=0x10
    repeat (2) applyStimulus(1'b1, 1'b1, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0);
    checkOutput("wait_bubble", 32'(IFID_Valid), 32'd0);
    checkOutput("wait_addr", imem_addr, 32'h10);
    applyStimulus(1'b1, 1'b1, 1'b0, 32'd0, 1'b0, 32'd0, 1'b1);
    checkOutput("wait_pc4", IFID_PC4, 32'h14);
    checkOutput("wait_instr", IFID_Instr, memWord(32'h10));

    // load-use stall while memory answers at pc=0x14
    applyStimulus(1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0, 1'b1);
    checkOutput("stall_req", 32'(imem_req), 32'd0);
    checkOutput("stall_pc4_hold", IFID_PC4, 32'h14);
    applyStimulus(1'b1, 1'b1, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0);
    checkOutput("stall_pc4", IFID_PC4, 32'h18);
    checkOutput("stall_instr", IFID_Instr, memWord(32'h14));
    checkOutput("stall_addr", imem_addr, 32'h18);

    // taken branch to an unaligned target while memory is ready
    applyStimulus(1'b1, 1'b1, 1'b1, 32'h43, 1'b0, 32'd0, 1'b1);
    checkOutput("branch_valid", 32'(IFID_Valid), 32'd0);
    checkOutput("branch_addr", imem_addr, 32'h40);

    // jump while the fetch at 0x40 is pending for three cycles
    applyStimulus(1'b1, 1'b1, 1'b0, 32'd0, 1'b1, 32'h100, 1'b0);
    repeat (2) applyStimulus(1'b1, 1'b1, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0);
    checkOutput("drain_addr", imem_addr, 32'h40);
    applyStimulus(1'b1, 1'b1, 1'b0, 32'd0, 1'b0, 32'd0, 1'b1);
    checkOutput("drain_new_addr", imem_addr, 32'h100);
    checkOutput("drain_valid", 32'(IFID_Valid), 32'd0);

    // reset while draining, then while buffered
    applyStimulus(1'b1, 1'b1, 1'b0, 32'd0, 1'b1, 32'h200, 1'b0);
    doReset();
    applyStimulus(1'b1, 1'b1, 1'b0, 32'd0, 1'b0, 32'd0, 1'b1);
    applyStimulus(1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0, 1'b1);
    doReset();

    // PC wrap
    applyStimulus(1'b1, 1'b1, 1'b0, 32'd0, 1'b1, 32'hFFFF_FFFC, 1'b1);
    applyStimulus(1'b1, 1'b1, 1'b0, 32'd0, 1'b0, 32'd0, 1'b1);
    checkOutput("wrap_pc4", IFID_PC4, 32'h0);
    checkOutput("wrap_addr", imem_addr, 32'h0);
    checkOutput("wrap_instr", IFID_Instr, memWord(32'hFFFF_FFFC));

    // randomized traffic
    for (int i = 0; i < 2000; i++) begin
      logic pcw, ifw, bt, j, rdy;
      pcw = ($urandom_range(0, 7) != 0);
      ifw = pcw ? ($urandom_range(0, 7) != 0) : ($urandom_range(0, 1) == 1);
      bt  = ($urandom_range(0, 9) == 0);
      j   = ($urandom_range(0, 9) == 0);
      rdy = ($urandom_range(0, 2) != 0);
      applyStimulus(pcw, ifw, bt, $urandom, j, $urandom, rdy);
      if ($urandom_range(0, 249) == 0) doReset();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
